// File: rtl/but_debounce_led.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM and press/release/long-press
// pulse generation, with LED1 following the clean level and LED2 toggling per press.
module but_debounce_led #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LONG_CYCLES     = 16,
    parameter logic        ACTIVE_LEVEL    = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BUT1,
    output logic LED1,
    output logic LED2,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] S_PRESSED      = 3'd2;
    localparam logic [2:0] S_LONG         = 3'd3;
    localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

    logic          sync1;
    logic          sync2;
    logic          act;
    logic [2:0]    state_q,     state_d;
    logic [DW-1:0] db_cnt_q,    db_cnt_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
    logic          from_long_q, from_long_d;
    logic          led1_d,      led2_d;
    logic          press_d,     release_d,  long_d;
    logic [DW-1:0] db_inc;
    logic [HW-1:0] hold_inc;

    assign act      = (sync2 == ACTIVE_LEVEL);
    assign db_inc   = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + DW'(1);
    assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);

    // State register, synchroniser and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1       <= ~ACTIVE_LEVEL;
            sync2       <= ~ACTIVE_LEVEL;
            state_q     <= S_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            from_long_q <= 1'b0;
            LED1        <= 1'b0;
            LED2        <= 1'b0;
            PRESS       <= 1'b0;
            RELEASE     <= 1'b0;
            LONG_PRESS  <= 1'b0;
        end else begin
            sync1       <= BUT1;
            sync2       <= sync1;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            from_long_q <= from_long_d;
            LED1        <= led1_d;
            LED2        <= led2_d;
            PRESS       <= press_d;
            RELEASE     <= release_d;
            LONG_PRESS  <= long_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        from_long_d = from_long_q;
        led1_d      = LED1;
        led2_d      = LED2;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (act) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = S_PRESSED;
                        db_cnt_d   = '0;
                        hold_cnt_d = '0;
                        press_d    = 1'b1;
                        led1_d     = 1'b1;
                        led2_d     = ~LED2;
                    end else begin
                        state_d  = S_PRESS_WAIT;
                        db_cnt_d = DW'(1);
                    end
                end
            end

            S_PRESS_WAIT: begin
                if (!act) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_inc == DB_MAX) begin
                    state_d    = S_PRESSED;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                    led1_d     = 1'b1;
                    led2_d     = ~LED2;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            S_PRESSED: begin
                if (act) begin
                    hold_cnt_d = hold_inc;
                    if (hold_inc == HOLD_MAX) begin
                        state_d = S_LONG;
                        long_d  = 1'b1;
                    end
                end else if (DEBOUNCE_CYCLES == 1) begin
                    // A single-sample debounce accepts the release immediately
                    state_d   = S_IDLE;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                    led1_d    = 1'b0;
                end else begin
                    state_d     = S_RELEASE_WAIT;
                    db_cnt_d    = DW'(1);
                    from_long_d = 1'b0;
                end
            end

            S_LONG: begin
                if (!act) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = S_IDLE;
                        db_cnt_d  = '0;
                        release_d = 1'b1;
                        led1_d    = 1'b0;
                    end else begin
                        state_d     = S_RELEASE_WAIT;
                        db_cnt_d    = DW'(1);
                        from_long_d = 1'b1;
                    end
                end
            end

            S_RELEASE_WAIT: begin
                // A bounce back to active resumes the pre-release state with the hold count intact
                if (act) begin
                    state_d  = from_long_q ? S_LONG : S_PRESSED;
                    db_cnt_d = '0;
                end else if (db_inc == DB_MAX) begin
                    state_d   = S_IDLE;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                    led1_d    = 1'b0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            default: begin
                state_d  = S_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_but_debounce_led.sv
// Directed bench for but_debounce_led: expected pulses (cycle, kind, LED levels) are queued
// when stimulus is applied and matched against every pulse the DUT emits.
module tb_but_debounce_led;

    localparam int K_PRESS = 1;
    localparam int K_REL   = 2;
    localparam int K_LONG  = 4;

    typedef struct {
        int   cyc;
        int   kind;
        logic led1;
        logic led2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic but1;
    logic led1, led2, press, rel, long_press;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   n_press  = 0;
    int   n_rel    = 0;
    logic exp_led2 = 1'b0;
    exp_t sb[$];

    but_debounce_led dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .BUT1       (but1),
        .LED1       (led1),
        .LED2       (led2),
        .PRESS      (press),
        .RELEASE    (rel),
        .LONG_PRESS (long_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int at, input int kind);
        exp_t e;
        if (kind == K_PRESS) exp_led2 = ~exp_led2;
        e.cyc  = at;
        e.kind = kind;
        e.led1 = (kind != K_REL);
        e.led2 = exp_led2;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_led1"}, int'(led1), 0);
        check({tag, "_led2"}, int'(led2), 0);
        check({tag, "_press"}, int'(press), 0);
        check({tag, "_rel"}, int'(rel), 0);
        check({tag, "_long"}, int'(long_press), 0);
    endtask

    // Pulse monitor: every pulse must match the head of the expectation queue
    always @(negedge clk) begin
        logic [2:0] p;
        exp_t e;
        p = {long_press, rel, press};
        check("onehot", int'($countones(p) <= 1), 1);
        if (press) n_press++;
        if (rel) n_rel++;
        if (p != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(p), 0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_kind", int'(p), e.kind);
                check("pulse_led1", int'(led1), int'(e.led1));
                check("pulse_led2", int'(led2), int'(e.led2));
            end
        end
    end

    initial begin
        int t;
        int p0, r0;
        logic [5:0] bounce;

        // Reset held with the button active
        rst_n = 1'b0;
        but1  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("reset");
        end
        rst_n = 1'b1;
        t = cyc;
        push(t + 6, K_PRESS);
        wait_n(10);
        but1 = 1'b0;
        t = cyc;
        push(t + 6, K_REL);
        wait_n(12);
        check("reset_seq_pending", sb.size(), 0);

        // Clean long press
        but1 = 1'b1;
        t = cyc;
        push(t + 6, K_PRESS);
        push(t + 22, K_LONG);
        wait_n(30);
        check("clean_led1_held", int'(led1), 1);
        wait_n(10);
        but1 = 1'b0;
        t = cyc;
        push(t + 6, K_REL);
        wait_n(12);
        check("clean_led1_after", int'(led1), 0);
        check("clean_pending", sb.size(), 0);

        // Press bounce 1,0,1,0,1,1 then idle: nothing accepted
        bounce = 6'b110101;
        for (int i = 0; i < 6; i++) begin
            but1 = bounce[i];
            @(negedge clk);
            check("pbounce_led1", int'(led1), 0);
        end
        but1 = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("pbounce_led1", int'(led1), 0);
        end
        check("pbounce_led2", int'(led2), int'(exp_led2));
        check("pbounce_pending", sb.size(), 0);

        // Release bounce while pressed: hold count resumes, long press delayed by the dip
        but1 = 1'b1;
        t = cyc;
        push(t + 6, K_PRESS);
        wait_n(10);
        but1 = 1'b0;
        wait_n(2);
        but1 = 1'b1;
        push(t + 25, K_LONG);
        wait_n(2);
        check("rbounce_led1", int'(led1), 1);
        wait_n(26);
        but1 = 1'b0;
        push(cyc + 6, K_REL);
        wait_n(12);
        check("rbounce_pending", sb.size(), 0);

        // Two separated clean presses
        p0 = n_press;
        r0 = n_rel;
        for (int i = 0; i < 2; i++) begin
            but1 = 1'b1;
            push(cyc + 6, K_PRESS);
            wait_n(10);
            check("two_led2", int'(led2), int'(exp_led2));
            but1 = 1'b0;
            push(cyc + 6, K_REL);
            wait_n(12);
        end
        check("two_press_count", n_press - p0, 2);
        check("two_rel_count", n_rel - r0, 2);
        check("two_pending", sb.size(), 0);

        // Reset while in the long-press state
        but1 = 1'b1;
        t = cyc;
        push(t + 6, K_PRESS);
        push(t + 22, K_LONG);
        wait_n(30);
        check("midlong_pending", sb.size(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("midlong_rst");
        exp_led2 = 1'b0;
        rst_n = 1'b1;
        push(cyc + 6, K_PRESS);
        wait_n(10);
        but1 = 1'b0;
        push(cyc + 6, K_REL);
        wait_n(12);
        check("midlong_final_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/but_debounce_led.md
Name: but_debounce_led

Overview:
- Receive-side conditioner for a raw push-button input (BUT1) in the button-to-LED designs.
- Synchronises and debounces the button, then classifies the activity as press, release or long press.
- Drives LED1 with the clean button level and toggles LED2 on each accepted press.
- Sits directly behind the BUT1 pin inside top-level designs and replaces the raw pin-to-LED wiring.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to accept a level change; legal range ≥1.
- LONG_CYCLES, 16: cycles in the pressed state before LONG_PRESS fires; legal range ≥1.
- ACTIVE_LEVEL, 1: BUT1 level that means "pressed"; 0 supports active-low buttons.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  synchronous reset, active-low.
- BUT1  input  1  raw, asynchronous, bouncing button pin.
- LED1  output  1  debounced button state; 1 = pressed.
- LED2  output  1  toggles on every accepted press.
- PRESS  output  1  one-cycle pulse when a press is accepted.
- RELEASE  output  1  one-cycle pulse when a release is accepted.
- LONG_PRESS  output  1  one-cycle pulse when a press has been held for LONG_CYCLES.

Behaviour:
- Reset: one clock, synchronous, active-low. While RST_N=0 at a rising edge:
  - LED1, LED2, PRESS, RELEASE and LONG_PRESS all go to 0.
  - Both synchroniser flops load the inactive level (~ACTIVE_LEVEL).
  - The debounce counter and the hold counter load 0.
  - The FSM goes to IDLE.
  - Reset overrides every other event, including mid-press; no RELEASE pulse is generated.
- Synchroniser: 2 flops on BUT1. act = (sync_out == ACTIVE_LEVEL).
- Debounce counter: width clog2(DEBOUNCE_CYCLES+1). Hold counter: width clog2(LONG_CYCLES+1). Both saturate and never wrap.
- FSM states: IDLE, PRESS_WAIT, PRESSED, LONG, RELEASE_WAIT.
  - IDLE:
    - act=1 → PRESS_WAIT with debounce counter = 1.
    - If DEBOUNCE_CYCLES=1, go straight to PRESSED with the press actions below.
  - PRESS_WAIT:
    - act=0 → IDLE, counter cleared.
    - act=1 → counter +1. When the counter reaches DEBOUNCE_CYCLES: go to PRESSED, PRESS=1 for one cycle, LED1←1, LED2←~LED2, hold counter ←0.
  - PRESSED:
    - act=1 → hold counter +1. When it reaches LONG_CYCLES: LONG_PRESS=1 for one cycle, go to LONG.
    - act=0 → RELEASE_WAIT with debounce counter = 1. The hold counter freezes.
  - LONG:
    - act=0 → RELEASE_WAIT with debounce counter = 1. No further LONG_PRESS.
  - RELEASE_WAIT:
    - act=1 (bounce) → return to the originating state (PRESSED or LONG, held in a 1-bit flag), counter cleared. The hold counter resumes from its frozen value. No pulse fires.
    - act=0 → counter +1. When it reaches DEBOUNCE_CYCLES: go to IDLE, RELEASE=1 for one cycle, LED1←0.
- LED1 = 1 in PRESSED, LONG and RELEASE_WAIT; LED1 = 0 otherwise. LED1 is registered.
- Latency: BUT1 stable active before rising edge k (k=1 is the first edge at which BUT1 is active):
  - PRESS and LED1 rise after edge k+DEBOUNCE_CYCLES+1.
  - Default parameters: PRESS visible after the 6th edge, high for exactly one cycle.
- Release latency is symmetric: 6 edges with default parameters.
- Pulses are registered outputs with no combinational path from BUT1.
- PRESS, RELEASE and LONG_PRESS are mutually exclusive in any cycle.
- Any bounce shorter than DEBOUNCE_CYCLES synchronised samples produces no pulse and no LED change.

Test Plan:
- Reset with BUT1 held at 1 for 3 cycles → all outputs 0 during reset. After RST_N=1, PRESS fires at the 6th edge with no pulse earlier.
- Clean press, BUT1=1 for 40 cycles, then 0:
  - PRESS at edge 6; LED1=1 and LED2 0→1 at edge 6.
  - LONG_PRESS at edge 22.
  - RELEASE 6 edges after the fall; LED1=0.
- Press bounce, BUT1 toggling 1,0,1,0,1,1 at one cycle each, then 0 → no PRESS, LED1 stays 0, FSM returns to IDLE.
- Release bounce: during PRESSED, BUT1=0 for 2 cycles then 1 → no RELEASE, LED1 stays 1, no LONG_PRESS until the hold count reaches 16 pressed cycles total.
- Two separated clean presses → LED2 sequence 0→1→0, exactly 2 PRESS and 2 RELEASE pulses.
- Reset mid-LONG: RST_N=0 for 1 cycle while BUT1=1 → all outputs 0 next edge, no RELEASE. After reset with BUT1 still 1 → new PRESS at the 6th edge.
